// File: rtl/switch_pkg.sv
// Shared definitions for the switch output-port reader: FSM states and
// header layout of a packet (DA, SA, LEN, payload, FCS).
package switch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        FCS,
        END
    } state_t;

    typedef enum logic [1:0] {
        DA_OFS  = 2'd0,
        SA_OFS  = 2'd1,
        LEN_OFS = 2'd2
    } hdr_ofs_t;

    localparam logic [1:0] HDR_LEN = 2'd3;

endpackage

// File: rtl/port_rx_fifo.sv
// Small synchronous FIFO buffering tagged bytes between the switch port
// and the downstream consumer; head entry is visible without a pop.
module port_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        free     = CW'(DEPTH) - count;
        pop_data = mem[rd_ptr];
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_port_reader.sv
// Reads one packet at a time from a switch output port, checks DA/FCS/length
// and forwards the bytes with sop/eop tags through a small output FIFO.
module switch_port_reader
    import switch_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              read,
    input  logic [DATA_W-1:0] port_data,
    input  logic [DATA_W-1:0] my_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              pkt_done,
    output logic              fcs_err,
    output logic              da_err,
    output logic              len_err,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam int FW = DATA_W + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = DATA_W + 1;

    state_t          state;
    state_t          next_state;
    logic [LW-1:0]   rd_left;
    logic            under_pend;
    logic            cap_vld;
    logic            cap_sop;
    logic            cap_len;
    logic            cap_fcs;
    logic [DATA_W-1:0] crc;
    logic [1:0]      hdr_idx;
    logic            active;
    logic            due;
    logic            underrun;
    logic            filler_push;
    logic            start;
    logic            push;
    logic [FW-1:0]   push_data;
    logic [FW-1:0]   pop_data;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_free;

    // Reads need two free slots because the previous byte may still be in flight.
    always_comb begin
        hdr_idx     = HDR_LEN - rd_left[1:0];
        start       = (state == IDLE) && ready;
        active      = (state == HDR) || (state == PAYLOAD) || (state == FCS);
        due         = active && (rd_left != '0) && !under_pend;
        read        = due && ready && (fifo_free >= CW'(2));
        underrun    = due && !ready;
        filler_push = under_pend && !fifo_full;
        push        = cap_vld || filler_push;
        push_data   = filler_push ? {1'b0, 1'b1, {DATA_W{1'b0}}}
                                  : {cap_sop, cap_fcs, port_data};
        pkt_done    = (state == END);
    end

    always_comb begin
        out_valid = !fifo_empty;
        pop       = out_valid && out_ready;
        {out_sop, out_eop, out_data} = out_valid ? pop_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ready) next_state = HDR;
            HDR: begin
                if (filler_push) begin
                    next_state = END;
                end else if (cap_vld && cap_len) begin
                    next_state = (port_data == '0) ? FCS : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (filler_push) begin
                    next_state = END;
                end else if (read && rd_left == LW'(1)) begin
                    next_state = FCS;
                end
            end
            FCS: begin
                if (filler_push || (cap_vld && cap_fcs)) begin
                    next_state = END;
                end
            end
            END:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The last payload read reloads the counter with the single FCS read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_left    <= '0;
            under_pend <= 1'b0;
            cap_vld    <= 1'b0;
            cap_sop    <= 1'b0;
            cap_len    <= 1'b0;
            cap_fcs    <= 1'b0;
            crc        <= '0;
            fcs_err    <= 1'b0;
            da_err     <= 1'b0;
            len_err    <= 1'b0;
            pkt_count  <= '0;
        end else begin
            cap_vld <= read;
            cap_sop <= read && (state == HDR) && (hdr_idx == DA_OFS);
            cap_len <= read && (state == HDR) && (hdr_idx == LEN_OFS);
            cap_fcs <= read && (state == FCS);
            if (start) begin
                rd_left    <= LW'(HDR_LEN);
                under_pend <= 1'b0;
                crc        <= '0;
                fcs_err    <= 1'b0;
                da_err     <= 1'b0;
                len_err    <= 1'b0;
            end else begin
                if (cap_vld && cap_len) begin
                    rd_left <= (port_data == '0) ? LW'(1) : LW'(port_data);
                end else if (read) begin
                    rd_left <= (state == PAYLOAD && rd_left == LW'(1)) ? LW'(1)
                                                                        : rd_left - LW'(1);
                end else if (underrun) begin
                    rd_left <= '0;
                end
                if (underrun) begin
                    under_pend <= 1'b1;
                    len_err    <= 1'b1;
                end else if (filler_push) begin
                    under_pend <= 1'b0;
                end
                if (cap_vld && !cap_fcs) begin
                    crc <= crc ^ port_data;
                end
                if (cap_vld && cap_sop) begin
                    da_err <= (port_data != my_addr);
                end
                if (cap_vld && cap_fcs) begin
                    fcs_err <= (port_data != crc);
                end
            end
            if (state == END) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    port_rx_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (pop_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free     (fifo_free)
    );

endmodule

// File: tb/tb_switch_port_reader.sv
// Directed bench for switch_port_reader: a table of packets with expected
// output streams and flags, plus stall, mid-packet reset and counter-wrap sequences.
module tb_switch_port_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            ready;
    logic            read;
    logic [DW-1:0]   port_data;
    logic [DW-1:0]   my_addr;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic            pkt_done;
    logic            fcs_err;
    logic            da_err;
    logic            len_err;
    logic [CNTW-1:0] pkt_count;

    switch_port_reader #(
        .DATA_W(DW),
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CNTW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .read     (read),
        .port_data(port_data),
        .my_addr  (my_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .pkt_done (pkt_done),
        .fcs_err  (fcs_err),
        .da_err   (da_err),
        .len_err  (len_err),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Switch port model: bytes appended by the stimulus, one returned the cycle after each read.
    logic [7:0] port_mem [256];
    int         rd_ptr;
    int         wr_pos;

    assign ready = (rd_ptr < wr_pos);

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= wr_pos;
            port_data <= 8'h00;
        end else if (read) begin
            port_data <= port_mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Output monitor: collects accepted bytes, done flags and hold-stability violations.
    logic [9:0] got_q[$];
    int         done_cnt  = 0;
    int         hold_viol = 0;
    logic       done_fcs  = 1'b0;
    logic       done_da   = 1'b0;
    logic       done_len  = 1'b0;
    logic       held_valid = 1'b0;
    logic [9:0] held_word  = '0;

    always @(negedge clk) begin
        if (reset) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid && (!out_valid || {out_sop, out_eop, out_data} != held_word)) begin
                hold_viol++;
            end
            held_valid = out_valid && !out_ready;
            held_word  = {out_sop, out_eop, out_data};
            if (out_valid && out_ready) begin
                got_q.push_back({out_sop, out_eop, out_data});
            end
            if (pkt_done) begin
                done_cnt++;
                done_fcs = fcs_err;
                done_da  = da_err;
                done_len = len_err;
            end
        end
    end

    typedef struct {
        string        name;
        logic [127:0] bytes;
        int           avail;
        logic [7:0]   addr;
        int           exp_nout;
        logic         exp_fcs;
        logic         exp_da;
        logic         exp_len;
        int           exp_count;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic appendBytes(input logic [127:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            port_mem[(wr_pos + i) % 256] = b[127 - 8*i -: 8];
        end
        wr_pos = wr_pos + n;
    endtask

    task automatic checkStream(input string tag, input logic [127:0] b, input int avail,
                               input int nout, input int base);
        logic [9:0] exp_w;
        logic [9:0] got_w;
        checkOutput({tag, "_nbytes"}, got_q.size() - base, nout);
        for (int i = 0; i < nout; i++) begin
            exp_w = {(i == 0), (i == nout - 1), (i < avail) ? b[127 - 8*i -: 8] : 8'h00};
            got_w = (base + i < got_q.size()) ? got_q[base + i] : 10'h3FF;
            checkOutput($sformatf("%s_byte%0d", tag, i), got_w, exp_w);
        end
    endtask

    task automatic waitDone(input string tag, input int d0);
        int c = 0;
        while (done_cnt == d0 && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int base;
        int d0;
        base    = got_q.size();
        d0      = done_cnt;
        my_addr = v.addr;
        appendBytes(v.bytes, v.avail);
        waitDone(v.name, d0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkStream(v.name, v.bytes, v.avail, v.exp_nout, base);
        checkOutput({v.name, "_fcs_err"}, done_fcs, v.exp_fcs);
        checkOutput({v.name, "_da_err"}, done_da, v.exp_da);
        checkOutput({v.name, "_len_err"}, done_len, v.exp_len);
        checkOutput({v.name, "_pkt_count"}, pkt_count, v.exp_count);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_read"}, read, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_sop"}, out_sop, 0);
        checkOutput({tag, "_out_eop"}, out_eop, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_pkt_done"}, pkt_done, 0);
        checkOutput({tag, "_flags"}, {fcs_err, da_err, len_err}, 0);
        checkOutput({tag, "_pkt_count"}, pkt_count, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] long_pkt;
        logic [127:0] short_pkt;
        vec_t         rst_vec;
        int           base;
        int           rbase;
        int           rd_base;
        int           d0;
        int           c;
        logic         seen;

        long_pkt  = {8'h01, 8'hAA, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                     8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hAA, 16'h0};
        short_pkt = {8'h01, 8'hAA, 8'h00, 8'hAB, 96'h0};

        vecs[0] = '{"good",     {8'h01, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h99, 80'h0},
                    6, 8'h01, 6, 1'b0, 1'b0, 1'b0, 1};
        vecs[1] = '{"fcs_bad",  {8'h01, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h98, 80'h0},
                    6, 8'h01, 6, 1'b1, 1'b0, 1'b0, 2};
        vecs[2] = '{"da_bad",   {8'h02, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h9A, 80'h0},
                    6, 8'h01, 6, 1'b0, 1'b1, 1'b0, 3};
        vecs[3] = '{"underrun", {8'h01, 8'hAA, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 72'h0},
                    7, 8'h01, 8, 1'b0, 1'b0, 1'b1, 4};
        vecs[4] = '{"len_zero", short_pkt, 4, 8'h01, 4, 1'b0, 1'b0, 1'b0, 5};
        rst_vec = '{"after_rst", short_pkt, 4, 8'h01, 4, 1'b0, 1'b0, 1'b0, 1};

        reset     = 1'b1;
        out_ready = 1'b1;
        my_addr   = 8'h01;
        wr_pos    = 0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset0");
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Consumer stall mid-packet: FIFO fills, reads stop, nothing lost.
        base    = got_q.size();
        rd_base = wr_pos;
        d0      = done_cnt;
        appendBytes(long_pkt, 14);
        c = 0;
        while (got_q.size() - base < 3 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        checkOutput("stall_read_low", read, 0);
        checkOutput("stall_fifo_fill", (rd_ptr - rd_base) - (got_q.size() - base), DEPTH);
        checkOutput("stall_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        waitDone("stall", d0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkStream("stall", long_pkt, 14, 14, base);
        checkOutput("stall_flags", {done_fcs, done_da, done_len}, 0);
        checkOutput("stall_pkt_count", pkt_count, 6);
        checkOutput("stall_hold_stable", hold_viol, 0);

        // Reset in the middle of the payload, then a clean zero-length packet.
        rd_base = wr_pos;
        appendBytes(long_pkt, 14);
        c = 0;
        while (rd_ptr - rd_base < 6 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        reset = 1'b1;
        #1;
        checkReset("reset_mid");
        rbase = got_q.size();
        d0    = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset_no_partial_done", done_cnt - d0, 0);
        applyStimulus(rst_vec);
        checkOutput("reset_only_new_bytes", got_q.size() - rbase, 4);

        // Back-to-back packets, next one offered while pkt_done is high; counter wraps to 0.
        appendBytes(short_pkt, 4);
        for (int i = 0; i < 7; i++) begin
            seen = 1'b0;
            c    = 0;
            while (!seen && c < 100) begin
                @(negedge clk); #1;
                if (pkt_done) seen = 1'b1;
                c++;
            end
            checkOutput($sformatf("wrap%0d_done_seen", i), seen, 1);
            checkOutput($sformatf("wrap%0d_count_at_done", i), pkt_count, (1 + i) % 8);
            if (i < 6) appendBytes(short_pkt, 4);
            @(posedge clk); #1;
            checkOutput($sformatf("wrap%0d_idle_gap", i), read, 0);
            checkOutput($sformatf("wrap%0d_count", i), pkt_count, (2 + i) % 8);
            if (i < 6) begin
                @(posedge clk); #1;
                checkOutput($sformatf("wrap%0d_next_read", i), read, 1);
            end
        end
        checkOutput("wrap_final_count", pkt_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
